alu_serial: RTL
===============

// Module: alu_serial
// PURPOSE
//  Multi-cycle, bit-serial WIDTH-bit ALU; next generation of the single-bit ALU slice.
//  Reuses one SLICE-bit adder/logic datapath for WIDTH/SLICE cycles per operation.
//  Carry is chained between slices. Produces a full result plus Z/N/C/V flags.
//  Sits between the decode stage and the register writeback.
//  Uses valid/ready handshakes on both the operand side and the result side.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of SLICE
//  SLICE   1  bits processed per cycle; N = WIDTH/SLICE cycles per operation
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      operands/opcode valid
//  in_ready    out  1      block can accept an operation (combinational, =1 only in IDLE)
//  opcode      in   4      operation select (map below)
//  a           in   WIDTH  operand A
//  b           in   WIDTH  operand B
//  out_valid   out  1      result/flags valid
//  out_ready   in   1      consumer accepts result
//  result      out  WIDTH  result
//  flags       out  4      {Z,N,C,V}
//  illegal     out  1      opcode 1101..1111 was issued
// BEHAVIOUR
//  Opcodes:
//   0000 ADD.
//   0001 SUB (A+~B+1).
//   0010 AND, 0011 OR, 0100 NOR, 0101 XOR, 0110 XNOR, 0111 NAND.
//   1000 PASSA, 1001 PASSB, 1010 ZERO.
//   1011 CMP: computes A-B; result=0; flags from the difference.
//   1100 SLT: result = {0..0, N^V} of A-B (signed less-than); flags from the difference.
//   1101..1111: result=0, flags=4'b1000, illegal=1.
//  Reset (async, rst_n=0):
//   - state=IDLE; out_valid=0; result=0; flags=0; illegal=0; carry and count cleared.
//   - in_ready=1 once out of reset.
//  FSM IDLE -> RUN -> DONE:
//   - IDLE: in_ready=1. On in_valid&in_ready, latch opcode, a, b into shift registers.
//     Set carry = 1 for SUB/CMP/SLT, else 0. count=0. Go to RUN.
//   - RUN: in_ready=0; in_valid is ignored. Each edge processes the low SLICE bits:
//     sum/logic bits shift into the result register from the MSB end; carry register
//     updates; count++. On the edge processing slice N-1, compute flags and go to DONE.
//   - DONE: out_valid=1. result, flags and illegal are held stable until out_ready=1.
//     On the out_valid&out_ready edge, out_valid drops to 0 and state goes to IDLE.
//     No new operation is accepted in that same cycle.
//  Latency: accept edge t0 -> out_valid=1 after edge t0+N.
//   Minimum issue interval is N+2 cycles when out_ready is held high.
//  Flags:
//   - Z = (result==0); for CMP/SLT, Z = (difference==0).
//   - N = MSB of result, or MSB of difference for CMP/SLT.
//   - C = carry out of the MSB (SUB: 1 = no borrow).
//   - V = carry-in(MSB) ^ carry-out(MSB).
//   - C=V=0 for logic, pass and ZERO ops.
//  Result/flags/illegal retain their last values in IDLE and RUN.
//   Only the DONE entry updates them.
//  Reset asserted mid-RUN or mid-DONE aborts the operation; the result is discarded.
// TESTING
//  1. W=16,S=1: ADD 7FFF+0001 -> result 8000, flags Z0 N1 C0 V1.
//     out_valid after exactly 16 cycles; in_ready=0 throughout.
//  2. SUB 0005-0007 -> FFFE, Z0 N1 C0 V0.
//     NAND FF00,0F0F -> F0FF, C=V=0.
//  3. CMP 1234,1234 -> result 0000, Z1 N0 C1 V0.
//     SLT 8000,0001 -> 0001.
//     SLT 0001,8000 -> 0000.
//  4. Backpressure: hold out_ready=0 for 5 cycles.
//     result/flags stay constant and in_ready=0.
//     A second in_valid during that time is ignored.
//     Then out_ready=1: one transfer, IDLE on the next cycle.
//  5. Assert rst_n=0 after slice 7 of an ADD.
//     Immediately: out_valid=0, result=0, flags=0.
//     After release: in_ready=1. Next ADD 0003+0004 -> 0007.
//  6. W=16,S=4: ADD FFFF+0001 -> 0000, Z1 C1, latency 4.
//     Opcode 1110 -> result 0, illegal=1.
//     A random sweep of all legal opcodes matches the golden model.

Source files
------------

// File: rtl/alu_serial_if.sv
// Operand/result handshake bundle for the bit-serial ALU.
// Master issues operations and consumes results; slave is the ALU.
interface alu_serial_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;
   logic             illegal;

   modport master (
      output in_valid, opcode, a, b, out_ready,
      input  in_ready, out_valid, result, flags, illegal
   );

   modport slave (
      input  in_valid, opcode, a, b, out_ready,
      output in_ready, out_valid, result, flags, illegal
   );
endinterface

// File: rtl/alu_serial.sv
// Bit-serial ALU: one SLICE-bit datapath reused WIDTH/SLICE times,
// carry chained between slices, result and {Z,N,C,V} flags on DONE.
module alu_serial #(
   parameter int WIDTH = 16,
   parameter int SLICE = 1
) (
   input logic         clk,
   input logic         rst_n,
   alu_serial_if.slave bus
);
   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = WIDTH - SLICE;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_NOR  = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_XNOR = 4'h6;
   localparam logic [3:0] OP_NAND = 4'h7;
   localparam logic [3:0] OP_PA   = 4'h8;
   localparam logic [3:0] OP_PB   = 4'h9;
   localparam logic [3:0] OP_CMP  = 4'hB;
   localparam logic [3:0] OP_SLT  = 4'hC;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e           state_q;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [PW-1:0]    acc_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] result_q;
   logic [3:0]       flags_q;
   logic             illegal_q;
   logic             out_valid_q;

   logic [SLICE-1:0] sl_a;
   logic [SLICE-1:0] sl_b;
   logic [SLICE-1:0] bx;
   logic [SLICE-1:0] sum;
   logic [SLICE-1:0] lg;
   logic [SLICE-1:0] sl_o;
   logic             c;
   logic             cin_msb;
   logic             cout;
   logic             inv_b;
   logic             arith;
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] res_d;
   logic [3:0]       flg_d;
   logic             ill_d;
   logic             sub_in;

   assign sub_in = (bus.opcode == OP_SUB) ||
                   (bus.opcode == OP_CMP) ||
                   (bus.opcode == OP_SLT);

   always_comb begin
      sl_a    = a_q[SLICE-1:0];
      sl_b    = b_q[SLICE-1:0];
      inv_b   = (op_q == OP_SUB) ||
                (op_q == OP_CMP) ||
                (op_q == OP_SLT);
      arith   = inv_b || (op_q == OP_ADD);
      bx      = inv_b ? ~sl_b : sl_b;
      c       = carry_q;
      cin_msb = 1'b0;
      sum     = '0;
      for (int i = 0; i < SLICE; i++) begin
         cin_msb = c;
         sum[i]  = sl_a[i] ^ bx[i] ^ c;
         c       = (sl_a[i] & bx[i]) |
                   (c & (sl_a[i] ^ bx[i]));
      end
      cout = c;
      case (op_q)
         OP_AND:  lg = sl_a & sl_b;
         OP_OR:   lg = sl_a | sl_b;
         OP_NOR:  lg = ~(sl_a | sl_b);
         OP_XOR:  lg = sl_a ^ sl_b;
         OP_XNOR: lg = ~(sl_a ^ sl_b);
         OP_NAND: lg = ~(sl_a & sl_b);
         OP_PA:   lg = sl_a;
         OP_PB:   lg = sl_b;
         default: lg = '0;
      endcase
      sl_o  = arith ? sum : lg;
      acc_d = {sl_o, acc_q};
   end

   // Final result/flags, only meaningful on the last RUN edge.
   always_comb begin
      ill_d = (op_q > OP_SLT);
      res_d = acc_d;
      flg_d = {acc_d == '0,
               acc_d[WIDTH-1],
               arith & cout,
               arith & (cin_msb ^ cout)};
      if (ill_d) begin
         res_d = '0;
         flg_d = 4'b1000;
      end else if (op_q == OP_CMP) begin
         res_d = '0;
      end else if (op_q == OP_SLT) begin
         res_d    = '0;
         res_d[0] = acc_d[WIDTH-1] ^ cin_msb ^ cout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         result_q    <= '0;
         flags_q     <= '0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  op_q    <= bus.opcode;
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  carry_q <= sub_in;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_q >> SLICE;
               b_q     <= b_q >> SLICE;
               acc_q   <= acc_d[WIDTH-1:SLICE];
               carry_q <= cout;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  result_q    <= res_d;
                  flags_q     <= flg_d;
                  illegal_q   <= ill_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;
   assign bus.illegal   = illegal_q;
endmodule
